fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned fetches under a credit limit, buffers
// in-order responses in a small FIFO and presents one instruction per cycle to Decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_Ps2,
  input  logic        Redirect_valid,
  input  logic [31:0] Redirect_pc,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_gnt,
  input  logic        Imem_rvalid,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] InstructionPs2,
  output logic [31:0] PcPs2,
  output logic        ValidPs2
);

  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam int          SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_fifo_pc    [DEPTH];
  logic [31:0]      r_fifo_instr [DEPTH];
  logic             r_valid_ps2;
  logic [31:0]      r_instr_ps2;
  logic [31:0]      r_pc_ps2;

  logic [SUM_W-1:0] w_credit;
  logic             w_req;
  logic             w_gnt_fire;
  logic             w_rsp;
  logic             w_accept;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic [CNT_W-1:0] w_outstanding_nxt;
  logic [31:0]      w_redirect_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffered plus in-flight entries never exceed DEPTH, so every response has a slot.
  assign w_credit   = SUM_W'(r_count) + SUM_W'(r_outstanding);
  assign w_req      = (r_state == RUN) && (w_credit < SUM_W'(DEPTH));
  assign w_gnt_fire = w_req && Imem_gnt;
  assign w_rsp      = Imem_rvalid && (r_outstanding != '0);
  assign w_accept   = w_rsp && (r_state != FLUSH) && !Redirect_valid;
  assign w_pop      = !Redirect_valid && !Stall_Ps2 && (r_count != '0);
  assign w_bypass   = !Redirect_valid && !Stall_Ps2 && (r_count == '0) && w_accept;
  assign w_push     = w_accept && !w_bypass;
  assign w_redirect_pc = Redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_gnt_fire, w_rsp})
      2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - CNT_W'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (Redirect_valid) begin
        // A grant in this cycle is counted as stale and does not advance past the target.
        r_pc       <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_outstanding_nxt;
        r_state    <= (w_outstanding_nxt != '0) ? FLUSH : RUN;
      end else begin
        if (w_gnt_fire) r_pc <= r_pc + 32'd4;
        if (w_accept)   r_rsp_pc <= r_rsp_pc + 32'd4;
        case (r_state)
          IDLE:    r_state <= RUN;
          RUN:     r_state <= RUN;
          FLUSH: begin
            if (w_rsp) begin
              r_drop_cnt <= r_drop_cnt - CNT_W'(1);
              if (r_drop_cnt == CNT_W'(1)) r_state <= RUN;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (Redirect_valid) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      r_fifo_instr[r_wr_ptr] <= Imem_rdata;
    end
  end

  // Ps2 boundary: FIFO head first, else a fresh response bypasses straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_ps2 <= 1'b0;
      r_instr_ps2 <= NOP;
      r_pc_ps2    <= 32'h0;
    end else if (Redirect_valid) begin
      r_valid_ps2 <= 1'b0;
      r_instr_ps2 <= NOP;
    end else if (!Stall_Ps2) begin
      if (r_count != '0) begin
        r_valid_ps2 <= 1'b1;
        r_instr_ps2 <= r_fifo_instr[r_rd_ptr];
        r_pc_ps2    <= r_fifo_pc[r_rd_ptr];
      end else if (w_accept) begin
        r_valid_ps2 <= 1'b1;
        r_instr_ps2 <= Imem_rdata;
        r_pc_ps2    <= r_rsp_pc;
      end else begin
        r_valid_ps2 <= 1'b0;
        r_instr_ps2 <= NOP;
      end
    end
  end

  assign Imem_req       = w_req;
  assign Imem_addr      = r_pc;
  assign ValidPs2       = r_valid_ps2;
  assign InstructionPs2 = r_instr_ps2;
  assign PcPs2          = r_pc_ps2;

  // IDLE is the post-reset window where abandoned responses may still trickle in.
  assert property (@(posedge clk) disable iff (rst)
    !(Imem_rvalid && (r_outstanding == '0) && (r_state == RUN)))
    else $error("fetch_unit: rvalid with no outstanding request");

endmodule
